// File: rtl/pencere_uretici_3x3.sv
// 3x3 neighbourhood window generator: raster pixel stream in, nine taps out.
// Optional end-of-frame pulse on done_o when PENCERE_DONE_EN is defined.
module pencere_uretici_3x3 #(
    parameter int GENISLIK  = 128,
    parameter int YUKSEKLIK = 128,
    parameter int VERI_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [VERI_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [VERI_W-1:0] g0_o,
    output logic [VERI_W-1:0] g1_o,
    output logic [VERI_W-1:0] g2_o,
    output logic [VERI_W-1:0] g3_o,
    output logic [VERI_W-1:0] g4_o,
    output logic [VERI_W-1:0] g5_o,
    output logic [VERI_W-1:0] g6_o,
    output logic [VERI_W-1:0] g7_o,
    output logic [VERI_W-1:0] g8_o,
    output logic              done_o
);

    localparam int SW = $clog2(GENISLIK);
    localparam int RW = $clog2(YUKSEKLIK);
    localparam logic [SW-1:0] SUTUN_SON = SW'(GENISLIK - 1);
    localparam logic [RW-1:0] SATIR_SON = RW'(YUKSEKLIK - 1);

    logic [SW-1:0]     sutun;
    logic [RW-1:0]     satir;
    logic              kabul;
    logic              sutun_son;
    logic              satir_son;
    logic              yayin;

    logic [VERI_W-1:0] lb0 [GENISLIK];
    logic [VERI_W-1:0] lb1 [GENISLIK];
    logic [VERI_W-1:0] lb0_rd_p0;
    logic [VERI_W-1:0] lb1_rd_p0;

    // Only the two older columns are stored; the newest column is live.
    logic [VERI_W-1:0] win_p0 [3][2];
    logic [VERI_W-1:0] kolon_p0 [3];
    logic [VERI_W-1:0] pencere_p0 [9];

    logic [VERI_W-1:0] taps_p1 [9];
    logic              vld_p1;

    assign in_ready_o = !vld_p1 || out_ready_i;
    assign kabul      = in_valid_i && in_ready_o;
    assign sutun_son  = (sutun == SUTUN_SON);
    assign satir_son  = (satir == SATIR_SON);
    assign yayin      = (satir >= RW'(2)) && (sutun >= SW'(2));

    assign lb0_rd_p0 = lb0[sutun];
    assign lb1_rd_p0 = lb1[sutun];

    always_comb begin
        kolon_p0[0] = lb0_rd_p0;
        kolon_p0[1] = lb1_rd_p0;
        kolon_p0[2] = in_data_i;
        for (int r = 0; r < 3; r++) begin
            pencere_p0[3*r]     = win_p0[r][0];
            pencere_p0[3*r + 1] = win_p0[r][1];
            pencere_p0[3*r + 2] = kolon_p0[r];
        end
    end

    // Stage p0: line buffers and column shift (data only, never reset)
    always_ff @(posedge clk_i) begin
        if (kabul) begin
            lb1[sutun] <= in_data_i;
            lb0[sutun] <= lb1_rd_p0;
            for (int r = 0; r < 3; r++) begin
                win_p0[r][0] <= win_p0[r][1];
                win_p0[r][1] <= kolon_p0[r];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sutun <= '0;
            satir <= '0;
        end else if (kabul) begin
            if (sutun_son) begin
                sutun <= '0;
                satir <= satir_son ? '0 : satir + 1'b1;
            end else begin
                sutun <= sutun + 1'b1;
            end
        end
    end

    // Stage p1: output window register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1  <= 1'b0;
            taps_p1 <= '{default: '0};
        end else if (kabul && yayin) begin
            vld_p1  <= 1'b1;
            taps_p1 <= pencere_p0;
        end else if (out_ready_i) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid_o = vld_p1;
    assign g0_o = taps_p1[0];
    assign g1_o = taps_p1[1];
    assign g2_o = taps_p1[2];
    assign g3_o = taps_p1[3];
    assign g4_o = taps_p1[4];
    assign g5_o = taps_p1[5];
    assign g6_o = taps_p1[6];
    assign g7_o = taps_p1[7];
    assign g8_o = taps_p1[8];

`ifdef PENCERE_DONE_EN
    logic son_p1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            son_p1 <= 1'b0;
        end else if (kabul && yayin) begin
            son_p1 <= satir_son && sutun_son;
        end
    end

    assign done_o = vld_p1 && out_ready_i && son_p1;
`else
    assign done_o = 1'b0;
`endif

endmodule
